// File: rtl/txn_frontend_pkg.sv
// Shared types for the transaction front-end: action codes, result codes,
// sequencer states and the packed command handed to the backend.
package txn_frontend_pkg;

  localparam int PKG_ID_W   = 8;
  localparam int PKG_DATA_W = 16;

  typedef enum logic [3:0] {
    ACT_READ  = 4'h1,
    ACT_WRITE = 4'h2,
    ACT_ADD   = 4'h4,
    ACT_XFER  = 4'h8
  } action_e;

  // Backend codes 1..0xD are passed through untouched and have no names here.
  typedef enum logic [3:0] {
    ERR_NONE    = 4'h0,
    ERR_TIMEOUT = 4'hE,
    ERR_PROTO   = 4'hF
  } err_msg_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_ID,
    S_GOT_ACT,
    S_ISSUE,
    S_WAIT_RSP,
    S_OUT
  } state_e;

  typedef struct packed {
    logic [3:0]            act;
    logic [PKG_ID_W-1:0]   id;
    logic [PKG_DATA_W-1:0] opnd;
  } cmd_t;

  function automatic logic is_known_act(input logic [3:0] code);
    return (code == ACT_READ) || (code == ACT_WRITE) ||
           (code == ACT_ADD)  || (code == ACT_XFER);
  endfunction

endpackage

// File: rtl/txn_gap_timer.sv
// Reusable down-counter: load sets the count, en decrements toward zero,
// expired is the terminal-count compare (count == 0).
module txn_gap_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load has priority over counting; the count parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/txn_frontend.sv
// Front-end transaction sequencer: parses the id/act/amnt input stream,
// issues one command to the backend and returns a single-cycle result.
// Optional watchdog on the backend round trip: define TXN_WATCHDOG_EN.
//
// state      | meaning
// S_IDLE     | waiting for id_valid or act_valid
// S_GOT_ID   | user id latched, waiting for act_valid
// S_GOT_ACT  | action latched, waiting for its operand (READ has none)
// S_ISSUE    | cmd_valid high, waiting for cmd_ready
// S_WAIT_RSP | command accepted, waiting for rsp_valid
// S_OUT      | one-cycle out_valid pulse
module txn_frontend
  import txn_frontend_pkg::*;
#(
  parameter int ID_W    = PKG_ID_W,
  parameter int DATA_W  = PKG_DATA_W,
  parameter int MAX_GAP = 5,
  parameter int TIMEOUT = 1200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              act_valid,
  input  logic              amnt_valid,
  input  logic [DATA_W-1:0] D,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [3:0]        cmd_act,
  output logic [ID_W-1:0]   cmd_id,
  output logic [DATA_W-1:0] cmd_opnd,
  input  logic              rsp_valid,
  input  logic [3:0]        rsp_err,
  output logic              out_valid,
  output logic [3:0]        err_msg,
  output logic              complete
);

  // Both timer instances share one width so they stay interchangeable.
  localparam int TMR_W = $clog2(((TIMEOUT > MAX_GAP) ? TIMEOUT : MAX_GAP) + 1);

  state_e          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
  logic [3:0]      err_q, err_d;
  logic            sticky_q;
  logic            any_v, multi_v, stray, act_ok, need_amnt;
  logic            gap_en, gap_load, gap_expired, gap_exp;
  logic            proto, accept_act, wd_exp;

  assign any_v     = id_valid | act_valid | amnt_valid;
  assign multi_v   = (id_valid & act_valid) | (id_valid & amnt_valid) | (act_valid & amnt_valid);
  assign act_ok    = is_known_act(D[3:0]);
  assign need_amnt = (cmd_q.act == ACT_WRITE) || (cmd_q.act == ACT_ADD);
  assign gap_en    = ((state_q == S_GOT_ID) || (state_q == S_GOT_ACT)) && !any_v;
  assign gap_exp   = gap_en && gap_expired;
  assign stray     = any_v && ((state_q == S_ISSUE) || (state_q == S_WAIT_RSP) || (state_q == S_OUT));

  txn_gap_timer #(.W(TMR_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (TMR_W'(MAX_GAP)),
    .en       (gap_en),
    .expired  (gap_expired)
  );

`ifdef TXN_WATCHDOG_EN
  logic wd_load, wd_en, wd_expired;
  // Loaded with TIMEOUT-1 on entry to ISSUE so OUT lands exactly TIMEOUT cycles later.
  assign wd_en   = (state_q == S_ISSUE) || (state_q == S_WAIT_RSP);
  assign wd_load = (state_d == S_ISSUE) && (state_q != S_ISSUE);
  txn_gap_timer #(.W(TMR_W)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (TMR_W'(TIMEOUT - 1)),
    .en       (wd_en),
    .expired  (wd_expired)
  );
  assign wd_exp = wd_en && wd_expired;
`else
  assign wd_exp = 1'b0;
`endif

  // Next-state and datapath capture; proto/accept_act collapse the common paths.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    last_id_d  = last_id_q;
    err_d      = err_q;
    gap_load   = 1'b0;
    proto      = 1'b0;
    accept_act = 1'b0;
    if (wd_exp) begin
      state_d = S_OUT;
      err_d   = ERR_TIMEOUT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (multi_v || amnt_valid) begin
            proto = 1'b1;
          end else if (id_valid) begin
            last_id_d = D[ID_W-1:0];
            gap_load  = 1'b1;
            state_d   = S_GOT_ID;
          end else if (act_valid) begin
            accept_act = 1'b1;
          end
        end
        S_GOT_ID: begin
          if (multi_v || id_valid || amnt_valid || gap_exp) proto = 1'b1;
          else if (act_valid) accept_act = 1'b1;
        end
        S_GOT_ACT: begin
          if (cmd_q.act == ACT_READ) begin
            if (any_v) proto = 1'b1;
            else state_d = S_ISSUE;
          end else if (multi_v || gap_exp) begin
            proto = 1'b1;
          end else if (amnt_valid && need_amnt) begin
            cmd_d.opnd = D;
            state_d    = S_ISSUE;
          end else if (id_valid && !need_amnt) begin
            cmd_d.opnd = {{(DATA_W-ID_W){1'b0}}, D[ID_W-1:0]};
            state_d    = S_ISSUE;
          end else if (any_v) begin
            proto = 1'b1;
          end
        end
        S_ISSUE:    if (cmd_ready) state_d = S_WAIT_RSP;
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            err_d   = rsp_err;
            state_d = S_OUT;
          end
        end
        S_OUT:      state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
      if (accept_act) begin
        if (act_ok) begin
          cmd_d.act  = D[3:0];
          cmd_d.id   = last_id_q;
          cmd_d.opnd = '0;
          gap_load   = 1'b1;
          state_d    = S_GOT_ACT;
        end else begin
          proto = 1'b1;
        end
      end
      if (proto) begin
        state_d = S_OUT;
        err_d   = ERR_PROTO;
      end
    end
  end

  // State and captured transaction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      last_id_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      last_id_q <= last_id_d;
      err_q     <= err_d;
    end
  end

  // Remembers valids dropped while busy; reported and cleared with the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= (sticky_q && !out_valid) || stray;
  end

  assign out_valid = (state_q == S_OUT);
  assign err_msg   = !out_valid ? ERR_NONE : (sticky_q ? ERR_PROTO : err_q);
  assign complete  = out_valid && (err_msg == ERR_NONE);
  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_act   = cmd_valid ? cmd_q.act  : '0;
  assign cmd_id    = cmd_valid ? cmd_q.id   : '0;
  assign cmd_opnd  = cmd_valid ? cmd_q.opnd : '0;

endmodule

// File: tb/tb_txn_frontend.sv
module tb_txn_frontend;

  localparam int ID_W    = 8;
  localparam int DATA_W  = 16;
  localparam int MAX_GAP = 5;
  localparam int TIMEOUT = 1200;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, act_valid, amnt_valid;
  logic [DATA_W-1:0] D;
  logic              cmd_valid, cmd_ready;
  logic [3:0]        cmd_act;
  logic [ID_W-1:0]   cmd_id;
  logic [DATA_W-1:0] cmd_opnd;
  logic              rsp_valid;
  logic [3:0]        rsp_err;
  logic              out_valid;
  logic [3:0]        err_msg;
  logic              complete;

  always #5 clk = ~clk;

  txn_frontend #(
    .ID_W(ID_W), .DATA_W(DATA_W), .MAX_GAP(MAX_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .act_valid(act_valid), .amnt_valid(amnt_valid), .D(D),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_act(cmd_act), .cmd_id(cmd_id), .cmd_opnd(cmd_opnd),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .out_valid(out_valid), .err_msg(err_msg), .complete(complete)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [27:0] exp_cmd_q[$];
  logic [3:0]  exp_out_q[$];
  logic [7:0]  m_last_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; act_valid = 1'b0; amnt_valid = 1'b0; D = '0;
  endtask

  // Drive one cycle of input; returns at the following negedge.
  task automatic cyc(input logic iv, input logic av, input logic mv, input logic [15:0] d);
    id_valid = iv; act_valid = av; amnt_valid = mv; D = d;
    @(negedge clk);
  endtask

  task automatic expect_cmd(input logic [3:0] act, input logic [7:0] id, input logic [15:0] opnd);
    exp_cmd_q.push_back({act, id, opnd});
  endtask

  // Backend side: wait for the command, stall rdy_wait cycles, then handshake.
  task automatic take_cmd(input int rdy_wait);
    int t;
    logic [27:0] e;
    idle_inputs();
    t = 0;
    while (!cmd_valid && t < 20) begin @(negedge clk); t++; end
    check("cmd_valid_seen", cmd_valid, 1);
    e = '1;
    if (exp_cmd_q.size() != 0) e = exp_cmd_q.pop_front();
    for (int k = 0; k < rdy_wait; k++) begin
      check("cmd_hold", {cmd_valid, cmd_act, cmd_id, cmd_opnd}, {1'b1, e});
      @(negedge clk);
    end
    check("cmd_fields", {cmd_valid, cmd_act, cmd_id, cmd_opnd}, {1'b1, e});
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("cmd_dropped", cmd_valid, 0);
  endtask

  task automatic wait_out();
    int t;
    logic [3:0] e;
    idle_inputs();
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    check("out_valid_seen", out_valid, 1);
    check("out_latency", t, 0);
    e = 4'hA;
    if (exp_out_q.size() != 0) e = exp_out_q.pop_front();
    check("err_msg", err_msg, e);
    check("complete", complete, (e == 4'h0));
    @(negedge clk);
    check("out_one_cycle", {out_valid, err_msg, complete}, 0);
  endtask

  task automatic respond(input int rsp_wait, input logic [3:0] code, input logic stray);
    if (stray) begin
      id_valid = 1'b1; D = 16'h0055;
      @(negedge clk);
      idle_inputs();
    end
    repeat (rsp_wait) @(negedge clk);
    rsp_valid = 1'b1; rsp_err = code;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = '0;
    wait_out();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    rst = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = '0; m_last_id = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_cmd_outs", {cmd_valid, cmd_act, cmd_id, cmd_opnd}, 0);
    check("rst_res_outs", {out_valid, err_msg, complete}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", {cmd_valid, out_valid, err_msg, complete}, 0);

    // READ with explicit id
    cyc(1, 0, 0, 16'h0012); m_last_id = 8'h12;
    cyc(0, 1, 0, 16'h0001);
    expect_cmd(4'h1, m_last_id, 16'h0000); exp_out_q.push_back(4'h0);
    take_cmd(0); respond(3, 4'h0, 1'b0);

    // WRITE reusing last id, backend error passed through
    cyc(0, 1, 0, 16'h0002);
    cyc(0, 0, 1, 16'h0400);
    expect_cmd(4'h2, m_last_id, 16'h0400); exp_out_q.push_back(4'h3);
    take_cmd(0); respond(3, 4'h3, 1'b0);

    // Exactly MAX_GAP idle cycles between id and act is still legal
    cyc(1, 0, 0, 16'h0056); m_last_id = 8'h56;
    for (int k = 0; k < MAX_GAP; k++) begin
      check("gap_ok_quiet", {out_valid, cmd_valid}, 0);
      cyc(0, 0, 0, 16'h0000);
    end
    cyc(0, 1, 0, 16'h0001);
    expect_cmd(4'h1, m_last_id, 16'h0000); exp_out_q.push_back(4'h0);
    take_cmd(0); respond(1, 4'h0, 1'b0);

    // MAX_GAP+1 idle cycles -> protocol error, no command
    cyc(1, 0, 0, 16'h0034); m_last_id = 8'h34;
    for (int k = 0; k < MAX_GAP + 1; k++) begin
      check("gap_bad_quiet", {out_valid, cmd_valid}, 0);
      cyc(0, 0, 0, 16'h0000);
    end
    exp_out_q.push_back(4'hF);
    wait_out();

    // XFER followed by amount instead of target id
    cyc(0, 1, 0, 16'h0008);
    cyc(0, 0, 1, 16'h0099);
    exp_out_q.push_back(4'hF);
    wait_out();

    // Unknown action code
    cyc(0, 1, 0, 16'h0007);
    exp_out_q.push_back(4'hF);
    wait_out();

    // Two valids in the same cycle
    cyc(1, 1, 0, 16'h0077);
    exp_out_q.push_back(4'hF);
    wait_out();

    // ADD with full-width operand, highest backend code
    cyc(0, 1, 0, 16'h0004);
    cyc(0, 0, 1, 16'hBEEF);
    expect_cmd(4'h4, m_last_id, 16'hBEEF); exp_out_q.push_back(4'hD);
    take_cmd(0); respond(0, 4'hD, 1'b0);

    // XFER with stalled backend and a stray id during WAIT_RSP
    cyc(1, 0, 0, 16'h0021); m_last_id = 8'h21;
    cyc(0, 1, 0, 16'h0008);
    cyc(1, 0, 0, 16'h03A7);
    expect_cmd(4'h8, m_last_id, 16'h00A7); exp_out_q.push_back(4'hF);
    take_cmd(10); respond(3, 4'h0, 1'b1);

    // Follow-up READ: target id must not have replaced last id; flag cleared
    cyc(0, 1, 0, 16'h0001);
    expect_cmd(4'h1, m_last_id, 16'h0000); exp_out_q.push_back(4'h5);
    take_cmd(2); respond(2, 4'h5, 1'b0);

`ifdef TXN_WATCHDOG_EN
    // Backend never accepts: timeout exactly TIMEOUT cycles after ISSUE entry
    cyc(0, 1, 0, 16'h0001);
    idle_inputs();
    t = 0;
    while (!cmd_valid && t < 20) begin @(negedge clk); t++; end
    check("wd_cmd_seen", cmd_valid, 1);
    t = 0;
    while (!out_valid && t < TIMEOUT + 20) begin @(negedge clk); t++; end
    check("wd_latency", t, TIMEOUT);
    check("wd_result", {out_valid, err_msg, complete, cmd_valid}, {1'b1, 4'hE, 1'b0, 1'b0});
    @(negedge clk);
    rsp_valid = 1'b1; rsp_err = 4'h2;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = '0;
    check("wd_late_rsp_ignored", out_valid, 0);
    repeat (2) @(negedge clk);
    cyc(0, 1, 0, 16'h0001);
    expect_cmd(4'h1, m_last_id, 16'h0000);
    take_cmd(0);
`else
    // Without the watchdog the block waits indefinitely for the response
    cyc(0, 1, 0, 16'h0001);
    expect_cmd(4'h1, m_last_id, 16'h0000);
    take_cmd(0);
    repeat (200) @(negedge clk);
    check("no_wd_still_waiting", {out_valid, cmd_valid}, 0);
`endif

    // Reset in WAIT_RSP together with a response: no pulse may survive
    rsp_valid = 1'b1; rsp_err = 4'h3; rst = 1'b1;
    #1;
    check("midrst_cmd_outs", {cmd_valid, cmd_act, cmd_id, cmd_opnd}, 0);
    check("midrst_res_outs", {out_valid, err_msg, complete}, 0);
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = '0;
    check("midrst_edge_outs", {out_valid, err_msg, complete, cmd_valid}, 0);
    rst = 1'b0; m_last_id = 8'h00;
    @(negedge clk);
    check("midrst_no_pulse", out_valid, 0);

    // After reset last id is zero
    cyc(0, 1, 0, 16'h0001);
    expect_cmd(4'h1, m_last_id, 16'h0000); exp_out_q.push_back(4'h0);
    take_cmd(0); respond(1, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
